fetch_unit: RTL and testbench

//  Instruction fetch stage between the byte-wide flash and the decode stage. Owns the PC,

---
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Flash byte bus and decode handshake for the fetch stage.
// master = fetch_unit, slave = flash model plus decode stage.
interface fetch_unit_if #(
    parameter int ADDR_W = 24
);
    logic              flash_cs;
    logic              flash_re;
    logic              flash_we;
    logic [ADDR_W-1:0] flash_addr;
    logic [7:0]        flash_dout;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output flash_cs,
        output flash_re,
        output flash_we,
        output flash_addr,
        input  flash_dout,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  flash_cs,
        input  flash_re,
        input  flash_we,
        input  flash_addr,
        output flash_dout,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: four flash byte reads per word, little-endian assembly, valid/ready out.
// Optional halt detection is enabled with FETCH_HALT_DETECT_EN.
module fetch_unit #(
    parameter int                ADDR_W    = 24,
    parameter int                READ_LAT  = 3,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       HALT_WORD = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    fetch_unit_if.master      bus,
    output logic              busy,
    output logic              halted
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
`ifdef FETCH_HALT_DETECT_EN
        , HALTED
`endif
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        idx;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        b0, b1, b2;

    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] pc_next;
    logic              accept;

    assign redir_pc = redirect_addr & ~ADDR_W'(3);
    assign pc_next  = pc + ADDR_W'(4);
    assign accept   = bus.instr_valid & bus.instr_ready;
    assign busy     = (state == ISSUE) || (state == WAIT);
    assign bus.flash_we = 1'b0;

`ifdef FETCH_HALT_DETECT_EN
    logic halted_q;
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            idx             <= 2'd0;
            cnt             <= '0;
            b0              <= 8'h0;
            b1              <= 8'h0;
            b2              <= 8'h0;
            bus.flash_cs    <= 1'b0;
            bus.flash_re    <= 1'b0;
            bus.flash_addr  <= '0;
            bus.instr       <= 32'h0;
            bus.instr_pc    <= '0;
            bus.instr_valid <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            halted_q        <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // Redirect wins over everything, including a same-cycle transfer.
            pc              <= redir_pc;
            idx             <= 2'd0;
            cnt             <= '0;
            bus.flash_cs    <= 1'b0;
            bus.flash_re    <= 1'b0;
            bus.instr_valid <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            halted_q        <= 1'b0;
`endif
            state           <= fetch_en ? ISSUE : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fetch_en) begin
                        state          <= ISSUE;
                        bus.flash_cs   <= 1'b1;
                        bus.flash_re   <= 1'b1;
                        bus.flash_addr <= {pc[ADDR_W-1:2], idx};
                    end
                end
                ISSUE: begin
                    // Entered from a redirect with the strobes still low: raise them first.
                    if (bus.flash_cs) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end else begin
                        bus.flash_cs   <= 1'b1;
                        bus.flash_re   <= 1'b1;
                        bus.flash_addr <= {pc[ADDR_W-1:2], idx};
                    end
                end
                WAIT: begin
                    if (cnt == CNT_LAST) begin
                        unique case (idx)
                            2'd0: b0 <= bus.flash_dout;
                            2'd1: b1 <= bus.flash_dout;
                            2'd2: b2 <= bus.flash_dout;
                            2'd3: bus.instr <= {bus.flash_dout, b2, b1, b0};
                        endcase
                        if (idx != 2'd3) begin
                            idx            <= idx + 2'd1;
                            bus.flash_addr <= {pc[ADDR_W-1:2], idx + 2'd1};
                            state          <= ISSUE;
                        end else begin
                            idx             <= 2'd0;
                            bus.flash_cs    <= 1'b0;
                            bus.flash_re    <= 1'b0;
                            bus.instr_pc    <= pc;
                            bus.instr_valid <= 1'b1;
                            state           <= HOLD;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (accept) begin
                        bus.instr_valid <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
                        if (bus.instr == HALT_WORD) begin
                            state    <= HALTED;
                            halted_q <= 1'b1;
                        end else
`endif
                        begin
                            pc <= pc_next;
                            if (fetch_en) begin
                                state          <= ISSUE;
                                bus.flash_cs   <= 1'b1;
                                bus.flash_re   <= 1'b1;
                                bus.flash_addr <= {pc_next[ADDR_W-1:2], 2'b00};
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
`ifdef FETCH_HALT_DETECT_EN
                HALTED: begin
                    state <= HALTED;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-accurate flash model, scoreboard of assembled words.
// Build with FETCH_HALT_DETECT_EN to exercise the halt path.
module tb_fetch_unit;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_en = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          busy;
    logic          halted;

    int checks = 0;
    int errors = 0;
    int n_acc = 0;

    logic [AW+31:0] exp_q[$];
    logic [AW-1:0]  addr_log[$];
    logic [7:0]     mem[logic [AW-1:0]];

    logic [AW-1:0] ap[3];
    logic [2:0]    av = 3'b000;
    logic          prev_cs = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [AW+31:0] sb_e;

    fetch_unit_if #(.ADDR_W(AW)) bus ();

    fetch_unit #(
        .ADDR_W   (AW),
        .READ_LAT (3),
        .RESET_PC (24'h000000),
        .HALT_WORD(32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .bus           (bus),
        .busy          (busy),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_at(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [31:0] exp_word(input logic [AW-1:0] a);
        return {mem_at(a + 3), mem_at(a + 2), mem_at(a + 1), mem_at(a)};
    endfunction

    // Flash: data valid only once the address has been held for three edges.
    always @(posedge clk) begin
        ap[0] <= bus.flash_addr;
        ap[1] <= ap[0];
        ap[2] <= ap[1];
        av    <= {av[1:0], bus.flash_cs & bus.flash_re};
    end

    assign bus.flash_dout = (bus.flash_cs && bus.flash_re && (&av) &&
                             ap[0] == bus.flash_addr && ap[1] == bus.flash_addr &&
                             ap[2] == bus.flash_addr) ? mem_at(ap[2]) : 8'hEE;

    initial begin
        forever begin
            @(negedge clk);
            if (rst && bus.flash_cs && bus.flash_re &&
                (!prev_cs || bus.flash_addr != prev_addr))
                addr_log.push_back(bus.flash_addr);
            prev_cs   = bus.flash_cs;
            prev_addr = bus.flash_addr;
            if (rst && bus.instr_valid && bus.instr_ready) begin
                n_acc++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra got pc=%h instr=%h expected none",
                             bus.instr_pc, bus.instr);
                end else begin
                    sb_e = exp_q.pop_front();
                    if ({bus.instr_pc, bus.instr} !== sb_e) begin
                        errors++;
                        $display("FAIL sb_word got pc=%h instr=%h expected pc=%h instr=%h",
                                 bus.instr_pc, bus.instr, sb_e[AW+31:32], sb_e[31:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [AW-1:0] a, input logic en, input logic en_after);
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = a;
        fetch_en       = en;
        tick();
        redirect_valid = 1'b0;
        fetch_en       = en_after;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] a);
        exp_q.push_back({a, exp_word(a)});
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.flash_cs, bus.flash_re, bus.flash_we, bus.instr_valid, busy, halted} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got cs=%b re=%b we=%b v=%b busy=%b halt=%b required all 0",
                     bus.flash_cs, bus.flash_re, bus.flash_we, bus.instr_valid, busy, halted);
        end
        checks++;
        if (bus.flash_addr !== '0 || bus.instr !== 32'h0 || bus.instr_pc !== '0) begin
            errors++;
            $display("FAIL reset_data got addr=%h instr=%h pc=%h required 0",
                     bus.flash_addr, bus.instr, bus.instr_pc);
        end
        tick();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.flash_cs !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_en got busy=%b cs=%b required 0 0", busy, bus.flash_cs);
        end
    endtask

    task automatic test_first_fetch();
        int cs_c = -1;
        int v_c = -1;
        bit ok;
        addr_log.delete();
        push_exp(24'h0);
        bus.instr_ready = 1'b1;
        tick();
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        for (int c = 0; c < 60 && v_c < 0; c++) begin
            @(negedge clk);
            if (bus.flash_cs && cs_c < 0) cs_c = c;
            if (bus.instr_valid) v_c = c;
        end
        checks++;
        if (v_c - cs_c != 16) begin
            errors++;
            $display("FAIL first_latency got %0d required 16", v_c - cs_c);
        end
        checks++;
        if (bus.instr !== 32'h02000283 || bus.instr_pc !== '0) begin
            errors++;
            $display("FAIL first_word got %h@%h required 02000283@000000",
                     bus.instr, bus.instr_pc);
        end
        repeat (3) tick();
        ok = (addr_log.size() == 4);
        for (int i = 0; i < 4 && ok; i++)
            if (addr_log[i] !== AW'(i)) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL first_addr_seq got %0d entries first=%h required 0,1,2,3",
                     addr_log.size(), addr_log.size() > 0 ? addr_log[0] : '1);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.flash_cs !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_idle got busy=%b cs=%b required 0 0", busy, bus.flash_cs);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit stable = 1'b1;
        logic [31:0] snap;
        logic [AW-1:0] snap_pc;
        tick();
        bus.instr_ready = 1'b0;
        fetch_en = 1'b1;
        push_exp(24'h4);
        push_exp(24'h8);
        wait_valid(cyc);
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL bp_timeout got no valid required valid");
        end
        snap = bus.instr;
        snap_pc = bus.instr_pc;
        tick();
        addr_log.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.instr !== snap || bus.instr_pc !== snap_pc || !bus.instr_valid ||
                bus.flash_cs || bus.flash_re)
                stable = 1'b0;
        end
        checks++;
        if (!stable || addr_log.size() != 0) begin
            errors++;
            $display("FAIL bp_hold got stable=%b accesses=%0d required 1 0",
                     stable, addr_log.size());
        end
        tick();
        bus.instr_ready = 1'b1;
        tick();
        fetch_en = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc < 0 || addr_log.size() == 0 || addr_log[0] !== 24'h8) begin
            errors++;
            $display("FAIL bp_next_addr got %h required 000008",
                     addr_log.size() > 0 ? addr_log[0] : '1);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int t[3] = '{default: 0};
        bit prev = 1'b0;
        bit dropped = 1'b0;
        push_exp(24'h40);
        push_exp(24'h44);
        push_exp(24'h48);
        redirect(24'h40, 1'b1, 1'b1);
        for (int c = 0; c < 200 && n < 3; c++) begin
            @(negedge clk);
            if (bus.instr_valid && !prev) begin
                t[n] = c;
                n++;
            end
            prev = bus.instr_valid;
            if (n == 2 && !dropped) begin
                tick();
                fetch_en = 1'b0;
                dropped = 1'b1;
            end
        end
        tick();
        checks++;
        if (n != 3 || t[1] - t[0] != 17) begin
            errors++;
            $display("FAIL b2b_space1 got %0d (n=%0d) required 17", t[1] - t[0], n);
        end
        checks++;
        if (n != 3 || t[2] - t[1] != 17) begin
            errors++;
            $display("FAIL b2b_space2 got %0d (n=%0d) required 17", t[2] - t[1], n);
        end
    endtask

    task automatic test_redirect_abort();
        int cyc = -1;
        fetch_en = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.flash_cs && bus.flash_addr[1:0] == 2'd2) begin
                cyc = c;
                break;
            end
        end
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL abort_byte2 got no byte-2 access required one");
        end
        tick();
        addr_log.delete();
        push_exp(24'h10);
        redirect_valid = 1'b1;
        redirect_addr  = 24'h000013;
        tick();
        redirect_valid = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc < 0 || bus.instr_pc !== 24'h10) begin
            errors++;
            $display("FAIL abort_pc got %h required 000010", bus.instr_pc);
        end
        checks++;
        if (addr_log.size() == 0 || addr_log[0] !== 24'h10) begin
            errors++;
            $display("FAIL abort_addr got %h required 000010",
                     addr_log.size() > 0 ? addr_log[0] : '1);
        end
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic test_halt();
        int cyc;
`ifdef FETCH_HALT_DETECT_EN
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || bus.flash_cs !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter got halted=%b busy=%b cs=%b required 1 0 0",
                     halted, busy, bus.flash_cs);
        end
        tick();
        fetch_en = 1'b1;
        addr_log.delete();
        repeat (20) tick();
        checks++;
        if (addr_log.size() != 0 || bus.flash_cs !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_stay got accesses=%0d halted=%b required 0 1",
                     addr_log.size(), halted);
        end
        push_exp(24'h0);
        redirect(24'h0, 1'b1, 1'b0);
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_clear got %b required 0", halted);
        end
        wait_valid(cyc);
        checks++;
        if (cyc < 0 || bus.instr_pc !== 24'h0 || bus.instr !== 32'h02000283) begin
            errors++;
            $display("FAIL halt_resume got %h@%h required 02000283@000000",
                     bus.instr, bus.instr_pc);
        end
        tick();
`else
        push_exp(24'h14);
        wait_valid(cyc);
        checks++;
        if (cyc < 0 || bus.instr_pc !== 24'h14 || halted !== 1'b0) begin
            errors++;
            $display("FAIL nohalt_next got pc=%h halted=%b required 000014 0",
                     bus.instr_pc, halted);
        end
        checks++;
        if (addr_log.size() < 5 || addr_log[4] !== 24'h14) begin
            errors++;
            $display("FAIL nohalt_addr got %0d entries required 000014 fifth",
                     addr_log.size());
        end
        tick();
`endif
    endtask

    task automatic test_redirect_accept();
        int cyc;
        int acc0;
        bus.instr_ready = 1'b0;
        push_exp(24'h80);
        redirect(24'h80, 1'b1, 1'b0);
        wait_valid(cyc);
        acc0 = n_acc;
        tick();
        bus.instr_ready = 1'b1;
        redirect_valid  = 1'b1;
        redirect_addr   = 24'h100;
        fetch_en        = 1'b1;
        push_exp(24'h100);
        tick();
        redirect_valid = 1'b0;
        fetch_en       = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc < 0 || bus.instr_pc !== 24'h100) begin
            errors++;
            $display("FAIL redir_acc_pc got %h required 000100", bus.instr_pc);
        end
        tick();
        checks++;
        if (n_acc - acc0 != 2) begin
            errors++;
            $display("FAIL redir_acc_count got %0d required 2", n_acc - acc0);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        push_exp(24'hFFFFFC);
        push_exp(24'h0);
        redirect(24'hFFFFFE, 1'b1, 1'b1);
        addr_log.delete();
        wait_valid(cyc);
        tick();
        fetch_en = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc < 0 || bus.instr_pc !== 24'h0) begin
            errors++;
            $display("FAIL wrap_pc got %h required 000000", bus.instr_pc);
        end
        checks++;
        if (addr_log.size() < 5 || addr_log[3] !== 24'hFFFFFF || addr_log[4] !== 24'h0) begin
            errors++;
            $display("FAIL wrap_addr got %0d entries required FFFFFC..FFFFFF,000000",
                     addr_log.size());
        end
        tick();
    endtask

    task automatic test_async_reset();
        int cyc;
        redirect(24'h20, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bus.flash_cs !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy got busy=%b cs=%b required 1 1", busy, bus.flash_cs);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.flash_cs, bus.flash_re, bus.instr_valid, busy, halted} !== 5'b0 ||
            bus.flash_addr !== '0 || bus.instr !== 32'h0 || bus.instr_pc !== '0) begin
            errors++;
            $display("FAIL async_reset got cs=%b re=%b v=%b busy=%b addr=%h instr=%h required 0",
                     bus.flash_cs, bus.flash_re, bus.instr_valid, busy, bus.flash_addr, bus.instr);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        addr_log.delete();
        push_exp(24'h0);
        tick();
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        wait_valid(cyc);
        checks++;
        if (cyc < 0 || addr_log.size() == 0 || addr_log[0] !== 24'h0 || bus.instr_pc !== 24'h0) begin
            errors++;
            $display("FAIL post_reset_pc got pc=%h required 000000", bus.instr_pc);
        end
        tick();
    endtask

    initial begin
        mem[24'h0]  = 8'h83;
        mem[24'h1]  = 8'h02;
        mem[24'h2]  = 8'h00;
        mem[24'h3]  = 8'h02;
        mem[24'h10] = 8'h00;
        mem[24'h11] = 8'h00;
        mem[24'h12] = 8'h00;
        mem[24'h13] = 8'h00;
        bus.instr_ready = 1'b0;

        test_reset();
        test_first_fetch();
        test_backpressure();
        test_back_to_back();
        test_redirect_abort();
        test_halt();
        test_redirect_accept();
        test_wrap();
        test_async_reset();

        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d words pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
